vme_bus_arbiter: RTL and testbench

- Shares one cern-be-vme slave port (e.g. a register/submap decoder block) between two cern-be-vme masters, m0 and m1.
- Captures single-cycle read/write strobes from each master and grants the slave to one master at a time using round-robin.
- Issues one registered strobe to the slave per granted request and routes Done and read data back to the owning master.
- A watchdog terminates transactions the slave never acknowledges, so a master cannot hang.

---
 rtl/vme_arb_pkg.sv | 21 ++
 rtl/vme_bus_arbiter_if.sv | 26 ++
 rtl/vme_arb_req_latch.sv | 68 ++++++
 rtl/vme_bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_vme_bus_arbiter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/vme_arb_pkg.sv
// Shared types and constants for the two-master VME slave-port arbiter.
//   state_e     : arbiter FSM states
//   KIND_RD/WR  : captured request kind
//   CNT_W       : watchdog counter width (TIMEOUT up to 2^16-1)
//   RD_ERR_DATA : read data returned on a watchdog timeout (all-ones)
package vme_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam logic KIND_RD = 1'b0;
    localparam logic KIND_WR = 1'b1;

    localparam int unsigned CNT_W      = 16;
    localparam int unsigned ERR_DW_MAX = 64;
    localparam logic [ERR_DW_MAX-1:0] RD_ERR_DATA = '1;

endpackage

// File: rtl/vme_bus_arbiter_if.sv
// cern-be-vme style register bus: address, write data, rd/wr strobes out;
// read data and rd/wr done back.
//   master modport : the side that issues strobes
//   slave  modport : the side that answers with Done/RdData
interface vme_bus_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32
) ();
    logic [AW-1:0] VMEAddr;
    logic [DW-1:0] VMEWrData;
    logic          VMERdMem;
    logic          VMEWrMem;
    logic [DW-1:0] VMERdData;
    logic          VMERdDone;
    logic          VMEWrDone;

    modport master (
        output VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
        input  VMERdData, VMERdDone, VMEWrDone
    );

    modport slave (
        input  VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
        output VMERdData, VMERdDone, VMEWrDone
    );
endinterface

// File: rtl/vme_arb_req_latch.sv
// Per-master request capture: holds one pending rd/wr request until granted.
//   Clk, Rst          : clock, synchronous active-high reset
//   rd_i, wr_i        : master strobes (write wins if both)
//   addr_i, wdata_i   : master address / write data
//   blocked_i         : this master already owns the slave; drop strobes
//   grant_i           : arbiter took the request; clear pending
//   pend_o, kind_o, addr_o, wdata_o : captured request
module vme_arb_req_latch
    import vme_arb_pkg::*;
#(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          rd_i,
    input  logic          wr_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          blocked_i,
    input  logic          grant_i,
    output logic          pend_o,
    output logic          kind_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] wdata_o
);

    logic          pend_q, pend_d;
    logic          kind_q, kind_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    // A strobe is only taken when nothing is queued or in service for this master.
    always_comb begin
        pend_d  = pend_q;
        kind_d  = kind_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (grant_i) begin
            pend_d = 1'b0;
        end else if ((rd_i || wr_i) && !pend_q && !blocked_i) begin
            pend_d  = 1'b1;
            kind_d  = wr_i ? KIND_WR : KIND_RD;
            addr_d  = addr_i;
            wdata_d = wdata_i;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pend_q  <= 1'b0;
            kind_q  <= KIND_RD;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            pend_q  <= pend_d;
            kind_q  <= kind_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign pend_o  = pend_q;
    assign kind_o  = kind_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;

endmodule

// File: rtl/vme_bus_arbiter.sv
// Round-robin arbiter sharing one VME slave port between masters m0 and m1,
// with a watchdog that force-completes unacknowledged transactions.
//   Clk, Rst       : clock, synchronous active-high reset
//   m0_bus, m1_bus : master-facing buses (arbiter answers Done/RdData)
//   s_bus          : slave-facing bus (arbiter issues strobes)
//   m0_Err, m1_Err : timeout flag, pulses with that master's Done
//   busy_o         : arbiter in ISSUE or WAIT
module vme_bus_arbiter
    import vme_arb_pkg::*;
#(
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Rst,
    vme_bus_arbiter_if.slave  m0_bus,
    vme_bus_arbiter_if.slave  m1_bus,
    vme_bus_arbiter_if.master s_bus,
    output logic              m0_Err,
    output logic              m1_Err,
    output logic              busy_o
);

    state_e state_q, state_d;

    logic             owner_q, owner_d;
    logic             rr_q, rr_d;       // master preferred on a tie
    logic             kind_q, kind_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    s_addr_q, s_addr_d;
    logic [DW-1:0]    s_wdata_q, s_wdata_d;
    logic             s_rd_q, s_rd_d;
    logic             s_wr_q, s_wr_d;
    logic [1:0]       rd_done_q, rd_done_d;
    logic [1:0]       wr_done_q, wr_done_d;
    logic [1:0]       err_q, err_d;
    logic [DW-1:0]    rdata_q [2];
    logic [DW-1:0]    rdata_d [2];

    logic [1:0]       pend_c, kind_c, grant_c, blocked_c;
    logic [AW-1:0]    addr_c  [2];
    logic [DW-1:0]    wdata_c [2];
    logic             sel_c, hit_c, timeout_c, complete_c, busy_c;

    assign busy_c       = (state_q != ST_IDLE);
    assign blocked_c[0] = busy_c && (owner_q == 1'b0);
    assign blocked_c[1] = busy_c && (owner_q == 1'b1);

    vme_arb_req_latch #(.AW(AW), .DW(DW)) u_req0 (
        .Clk(Clk), .Rst(Rst),
        .rd_i(m0_bus.VMERdMem), .wr_i(m0_bus.VMEWrMem),
        .addr_i(m0_bus.VMEAddr), .wdata_i(m0_bus.VMEWrData),
        .blocked_i(blocked_c[0]), .grant_i(grant_c[0]),
        .pend_o(pend_c[0]), .kind_o(kind_c[0]),
        .addr_o(addr_c[0]), .wdata_o(wdata_c[0])
    );

    vme_arb_req_latch #(.AW(AW), .DW(DW)) u_req1 (
        .Clk(Clk), .Rst(Rst),
        .rd_i(m1_bus.VMERdMem), .wr_i(m1_bus.VMEWrMem),
        .addr_i(m1_bus.VMEAddr), .wdata_i(m1_bus.VMEWrData),
        .blocked_i(blocked_c[1]), .grant_i(grant_c[1]),
        .pend_o(pend_c[1]), .kind_o(kind_c[1]),
        .addr_o(addr_c[1]), .wdata_o(wdata_c[1])
    );

    // Winner: the only pending master, else the tie-break preference.
    assign sel_c      = (pend_c[0] && pend_c[1]) ? rr_q : pend_c[1];
    // Only the Done matching the issued kind completes a transaction.
    assign hit_c      = (kind_q == KIND_WR) ? s_bus.VMEWrDone : s_bus.VMERdDone;
    assign timeout_c  = (state_q == ST_WAIT) && (cnt_q == '0);
    assign complete_c = busy_c && (hit_c || timeout_c);

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|pend_c)   state_d = ST_ISSUE;
            ST_ISSUE: state_d = complete_c ? ST_IDLE : ST_WAIT;
            ST_WAIT:  if (complete_c) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        owner_d   = owner_q;
        rr_d      = rr_q;
        kind_d    = kind_q;
        cnt_d     = cnt_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_rd_d    = 1'b0;
        s_wr_d    = 1'b0;
        rd_done_d = '0;
        wr_done_d = '0;
        err_d     = '0;
        rdata_d   = rdata_q;
        grant_c   = '0;

        if (state_q == ST_IDLE && (|pend_c)) begin
            grant_c[sel_c] = 1'b1;
            owner_d   = sel_c;
            kind_d    = kind_c[sel_c];
            s_addr_d  = addr_c[sel_c];
            s_wdata_d = wdata_c[sel_c];
            s_rd_d    = (kind_c[sel_c] == KIND_RD);
            s_wr_d    = (kind_c[sel_c] == KIND_WR);
        end

        if (state_q == ST_ISSUE) begin
            cnt_d = CNT_W'(TIMEOUT);
        end else if (state_q == ST_WAIT && !complete_c) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (complete_c) begin
            rr_d           = ~owner_q;
            err_d[owner_q] = !hit_c;
            if (kind_q == KIND_WR) begin
                wr_done_d[owner_q] = 1'b1;
            end else begin
                rd_done_d[owner_q] = 1'b1;
                rdata_d[owner_q]   = hit_c ? s_bus.VMERdData : DW'(RD_ERR_DATA);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            owner_q    <= 1'b0;
            rr_q       <= 1'b0;
            kind_q     <= KIND_RD;
            cnt_q      <= '0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_rd_q     <= 1'b0;
            s_wr_q     <= 1'b0;
            rd_done_q  <= '0;
            wr_done_q  <= '0;
            err_q      <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            kind_q     <= kind_d;
            cnt_q      <= cnt_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            s_rd_q     <= s_rd_d;
            s_wr_q     <= s_wr_d;
            rd_done_q  <= rd_done_d;
            wr_done_q  <= wr_done_d;
            err_q      <= err_d;
            rdata_q[0] <= rdata_d[0];
            rdata_q[1] <= rdata_d[1];
        end
    end

    assign s_bus.VMEAddr       = s_addr_q;
    assign s_bus.VMEWrData     = s_wdata_q;
    assign s_bus.VMERdMem      = s_rd_q;
    assign s_bus.VMEWrMem      = s_wr_q;
    assign m0_bus.VMERdData    = rdata_q[0];
    assign m0_bus.VMERdDone    = rd_done_q[0];
    assign m0_bus.VMEWrDone    = wr_done_q[0];
    assign m1_bus.VMERdData    = rdata_q[1];
    assign m1_bus.VMERdDone    = rd_done_q[1];
    assign m1_bus.VMEWrDone    = wr_done_q[1];
    assign m0_Err              = err_q[0];
    assign m1_Err              = err_q[1];
    assign busy_o              = busy_c;

endmodule

// File: tb/tb_vme_bus_arbiter.sv
// Randomized bench for vme_bus_arbiter. A transaction-level model tracks
// pending requests, the transaction in flight (issue cycle, deadline) and
// the tie-break preference, and predicts every registered output per cycle.
module tb_vme_bus_arbiter;

    localparam int unsigned AW   = 8;
    localparam int unsigned DW   = 32;
    localparam int unsigned TO   = 8;
    localparam int unsigned NCYC = 4000;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    logic m0_err, m1_err, busy;

    always #5 clk = ~clk;

    vme_bus_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
    vme_bus_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();
    vme_bus_arbiter_if #(.AW(AW), .DW(DW)) s_if ();

    vme_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .Clk(clk), .Rst(rst),
        .m0_bus(m0_if), .m1_bus(m1_if), .s_bus(s_if),
        .m0_Err(m0_err), .m1_Err(m1_err), .busy_o(busy)
    );

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Stimulus for the current cycle.
    logic          m_rd [2];
    logic          m_wr [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wdata [2];
    logic          s_rdd, s_wrd;
    logic [DW-1:0] s_rdata;

    // Model state.
    bit   pend [2];
    req_t preq [2];
    bit   act;
    int   act_m, act_start, ack_cyc, rr;
    bit   noack, did_rst;
    req_t act_r;

    // Predicted outputs for the next sample.
    logic          e_srd, e_swr, e_busy;
    logic [AW-1:0] e_saddr;
    logic [DW-1:0] e_swdata;
    logic [1:0]    e_rdone, e_wdone, e_err;
    logic [DW-1:0] e_rdata [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            pend[i]    = 1'b0;
            e_rdata[i] = '0;
        end
        act = 1'b0; rr = 0; act_m = 0; act_start = 0; ack_cyc = 0; noack = 1'b0;
        e_srd = 1'b0; e_swr = 1'b0; e_busy = 1'b0;
        e_saddr = '0; e_swdata = '0;
        e_rdone = '0; e_wdone = '0; e_err = '0;
    endtask

    // Advance the model over cycle 'cyc' using this cycle's inputs.
    task automatic model_step();
        bit blk [2];
        bit hit;
        int g;
        if (rst) begin
            model_reset();
            return;
        end
        e_srd = 1'b0; e_swr = 1'b0;
        e_rdone = '0; e_wdone = '0; e_err = '0;
        for (int i = 0; i < 2; i++) blk[i] = pend[i] || (act && act_m == i);

        if (act) begin
            hit = act_r.wr ? s_wrd : s_rdd;
            if (hit || cyc == act_start + 1 + int'(TO)) begin
                if (act_r.wr) e_wdone[act_m] = 1'b1;
                else begin
                    e_rdone[act_m] = 1'b1;
                    e_rdata[act_m] = hit ? s_rdata : {DW{1'b1}};
                end
                e_err[act_m] = !hit;
                rr  = 1 - act_m;
                act = 1'b0;
            end
        end else if (pend[0] || pend[1]) begin
            g = (pend[0] && pend[1]) ? rr : (pend[1] ? 1 : 0);
            act = 1'b1; act_m = g; act_r = preq[g]; act_start = cyc + 1;
            pend[g]  = 1'b0;
            e_saddr  = act_r.addr;
            e_swdata = act_r.wdata;
            e_srd    = !act_r.wr;
            e_swr    = act_r.wr;
            // Slave behaviour for this transaction.
            noack = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 9) == 0) ack_cyc = act_start + $urandom_range(0, TO + 3);
            else                           ack_cyc = act_start + $urandom_range(0, 3);
        end

        for (int i = 0; i < 2; i++) begin
            if ((m_rd[i] || m_wr[i]) && !blk[i]) begin
                pend[i] = 1'b1;
                preq[i] = '{wr: m_wr[i], addr: m_addr[i], wdata: m_wdata[i]};
            end
        end
        e_busy = act;
    endtask

    task automatic check_outputs();
        chk("s_rdmem",   64'(s_if.VMERdMem),    64'(e_srd));
        chk("s_wrmem",   64'(s_if.VMEWrMem),    64'(e_swr));
        chk("s_addr",    64'(s_if.VMEAddr),     64'(e_saddr));
        chk("s_wrdata",  64'(s_if.VMEWrData),   64'(e_swdata));
        chk("m0_rddone", 64'(m0_if.VMERdDone),  64'(e_rdone[0]));
        chk("m0_wrdone", 64'(m0_if.VMEWrDone),  64'(e_wdone[0]));
        chk("m0_err",    64'(m0_err),           64'(e_err[0]));
        chk("m0_rddata", 64'(m0_if.VMERdData),  64'(e_rdata[0]));
        chk("m1_rddone", 64'(m1_if.VMERdDone),  64'(e_rdone[1]));
        chk("m1_wrdone", 64'(m1_if.VMEWrDone),  64'(e_wdone[1]));
        chk("m1_err",    64'(m1_err),           64'(e_err[1]));
        chk("m1_rddata", 64'(m1_if.VMERdData),  64'(e_rdata[1]));
        chk("busy",      64'(busy),             64'(e_busy));
    endtask

    task automatic drive_inputs();
        m0_if.VMERdMem = m_rd[0];  m0_if.VMEWrMem = m_wr[0];
        m0_if.VMEAddr  = m_addr[0]; m0_if.VMEWrData = m_wdata[0];
        m1_if.VMERdMem = m_rd[1];  m1_if.VMEWrMem = m_wr[1];
        m1_if.VMEAddr  = m_addr[1]; m1_if.VMEWrData = m_wdata[1];
        s_if.VMERdDone = s_rdd; s_if.VMEWrDone = s_wrd; s_if.VMERdData = s_rdata;
    endtask

    initial begin
        int r;
        bit match_line;
        rst = 1'b1;
        did_rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_rd[i] = 1'b0; m_wr[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0;
        end
        s_rdd = 1'b0; s_wrd = 1'b0; s_rdata = '0;
        drive_inputs();
        model_reset();
        @(negedge clk);

        for (int t = 0; t < int'(NCYC); t++) begin
            check_outputs();

            // Occasional reset, plus one forced while a transaction waits.
            if (!did_rst && cyc > 400 && act && cyc > act_start) begin
                rst = 1'b1; did_rst = 1'b1;
            end else begin
                rst = ($urandom_range(0, 299) == 0);
            end

            for (int i = 0; i < 2; i++) begin
                r = $urandom_range(0, 9);
                m_rd[i]    = (r <= 1) || (r == 4);
                m_wr[i]    = (r == 2) || (r == 3) || (r == 4);
                m_addr[i]  = AW'($urandom());
                m_wdata[i] = DW'($urandom());
            end

            // Matching Done only on the planned cycle; the other line is noise.
            s_rdd = ($urandom_range(0, 99) < 15);
            s_wrd = ($urandom_range(0, 99) < 15);
            if (act) begin
                match_line = !noack && (cyc == ack_cyc);
                if (act_r.wr) s_wrd = match_line;
                else          s_rdd = match_line;
            end
            s_rdata = DW'($urandom());

            drive_inputs();
            model_step();
            cyc++;
            @(negedge clk);
        end
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
